zf_backsub_row: RTL

- Generalised back-substitution row engine for the ZF detector. Computes x_out = y_in − Σ_{j=0..NUM_TERMS−1} R_j·x_j over complex IEEE-754 single values.
- Sits between the Q^H·y stage and the diagonal-scaling stage. One instance per row of an NxN upper-triangular solve, with NUM_TERMS = number of already-solved elements for that row.
- Time-multiplexes 2 floating-point multipliers and 2 floating-point adders across terms, driven by an enable/accept handshake FSM.

---
 rtl/zf_backsub_row.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/zf_backsub_row.sv
// zf_backsub_row: one row of the ZF upper-triangular back-substitution.
//   x_out = y_in - sum_j R_j * x_j over complex single-precision values, with
//   terms j = 0 upward and a fixed accumulation order for bit-exact results.
// Ports: clk, reset_n (async, active-low); enable/accept_out start a row (IDLE only);
//   y_in, r_row, x_solved are captured at the start edge; x_out/ready_out present the
//   result until accept_in is seen in DONE.
// Latency: ready_out rises 2 + 3*NUM_TERMS edges after the start edge
//   (2 + 2*NUM_TERMS with ZF_REAL_R_EN).
// Macro ZF_REAL_R_EN: R is real-only; the imaginary field of r_row is ignored and
//   each term takes two cycles (MA, MB).
module zf_backsub_row #(
  parameter int NUM_TERMS = 2,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  output logic                    accept_out,
  input  logic [63:0]             y_in,
  input  logic [64*NUM_TERMS-1:0] r_row,
  input  logic [64*NUM_TERMS-1:0] x_solved,
  output logic [63:0]             x_out,
  output logic                    ready_out,
  input  logic                    accept_in
);

  typedef enum logic [2:0] {IDLE, LOAD, MA, MB, MC, DONE} state_t;

  // Single-precision multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, g, st, up;
    logic [47:0]       p;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    up = g & (st | m[0]);
    mr = {1'b0, m} + {24'd0, up};
    if (mr[24]) begin
      m = mr[24:1]; e = e + 10'sd1;
    end else begin
      m = mr[23:0];
    end
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return 32'h7FC0_0000;
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    else if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)   return {s, 31'd0};
    else                    return {s, e[7:0], m[22:0]};
  endfunction

  // Single-precision add, round-to-nearest-even; subnormals flush to zero.
  // Mantissas carry guard/round/sticky in the low three bits.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       l, sm;
    logic [7:0]        d8;
    logic [4:0]        sh, lz;
    logic [49:0]       ext;
    logic [26:0]       ml, ms, nm;
    logic [27:0]       sum;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              g, st, up, found;
    logic signed [9:0] e;
    if (a[30:0] >= b[30:0]) begin l = a; sm = b; end
    else                    begin l = b; sm = a; end
    d8  = l[30:23] - sm[30:23];
    sh  = (d8 > 8'd31) ? 5'd31 : d8[4:0];
    ml  = {1'b1, l[22:0], 3'b000};
    ext = {1'b1, sm[22:0], 26'd0} >> sh;
    ms  = {ext[49:24], |ext[23:0]};
    sum = (l[31] ^ sm[31]) ? ({1'b0, ml} - {1'b0, ms}) : ({1'b0, ml} + {1'b0, ms});
    e   = $signed({2'b00, l[30:23]});
    lz  = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      e  = e + 10'sd1;
    end else begin
      nm = sum[26:0] << lz;
      e  = e - $signed({5'd0, lz});
    end
    m  = nm[26:3];
    g  = nm[2];
    st = nm[1] | nm[0];
    up = g & (st | m[0]);
    mr = {1'b0, m} + {24'd0, up};
    if (mr[24]) begin
      m = mr[24:1]; e = e + 10'sd1;
    end else begin
      m = mr[23:0];
    end
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return 32'h7FC0_0000;
    else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
    else if (a[30:23] == 8'hFF) return a;
    else if (b[30:23] == 8'hFF) return b;
    else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    else if (a[30:23] == 8'd0) return b;
    else if (b[30:23] == 8'd0) return a;
    else if (sum == 28'd0)     return 32'd0;
    else if (e >= 10'sd255)    return {l[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0)      return {l[31], 31'd0};
    else                       return {l[31], e[7:0], m[22:0]};
  endfunction

  state_t                  state_q, state_d;
  logic                    settle_q, settle_d;
  logic [CNT_W-1:0]        k_q, k_d;
  logic [63:0]             y_q, y_d;
  logic [64*NUM_TERMS-1:0] r_q, r_d, xs_q, xs_d;
  logic [31:0]             acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [31:0]             m1a_q, m1a_d, m1b_q, m1b_d, m2a_q, m2a_d, m2b_q, m2b_d;
  logic [63:0]             x_out_q, x_out_d;
  logic                    ready_q, ready_d;

  logic [63:0] r_cur, x_cur;
  logic [31:0] prod1, prod2, sum_re, sum_im;
  logic        last;

  // Select the current term's R and x from the captured row.
  always_comb begin
    r_cur = '0;
    x_cur = '0;
    for (int j = 0; j < NUM_TERMS; j++) begin
      if (k_q == CNT_W'(j)) begin
        r_cur = r_q[64*j +: 64];
        x_cur = xs_q[64*j +: 64];
      end
    end
  end

  assign last  = (k_q == CNT_W'(NUM_TERMS - 1));
  assign prod1 = fp_mul(m1a_q, m1b_q);
  assign prod2 = fp_mul(m2a_q, m2b_q);
  // Real path subtracts in MB and adds in MC; imaginary path always subtracts.
  assign sum_re = fp_add(acc_re_q, {prod1[31] ^ (state_q == MB), prod1[30:0]});
  assign sum_im = fp_add(acc_im_q, {~prod2[31], prod2[30:0]});

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    k_d      = k_q;
    y_d      = y_q;
    r_d      = r_q;
    xs_d     = xs_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    m1a_d    = m1a_q;
    m1b_d    = m1b_q;
    m2a_d    = m2a_q;
    m2b_d    = m2b_q;
    x_out_d  = x_out_q;
    case (state_q)
      IDLE: if (enable) begin
        y_d      = y_in;
        r_d      = r_row;
        xs_d     = x_solved;
        settle_d = 1'b0;
        state_d  = LOAD;
      end
      // LOAD spans two cycles, fixing the row latency at 2 + per-term cycles.
      LOAD: begin
        acc_re_d = y_q[63:32];
        acc_im_d = y_q[31:0];
        k_d      = '0;
        settle_d = ~settle_q;
        if (settle_q) state_d = MA;
      end
      MA: begin
        m1a_d = r_cur[63:32]; m1b_d = x_cur[63:32];
        m2a_d = r_cur[63:32]; m2b_d = x_cur[31:0];
        state_d = MB;
      end
      MB: begin
        acc_re_d = sum_re;
        acc_im_d = sum_im;
`ifdef ZF_REAL_R_EN
        if (last) begin
          x_out_d = {sum_re, sum_im};
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = MA;
        end
`else
        m1a_d = r_cur[31:0]; m1b_d = x_cur[31:0];
        m2a_d = r_cur[31:0]; m2b_d = x_cur[63:32];
        state_d = MC;
`endif
      end
`ifndef ZF_REAL_R_EN
      MC: begin
        acc_re_d = sum_re;
        acc_im_d = sum_im;
        if (last) begin
          x_out_d = {sum_re, sum_im};
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = MA;
        end
      end
`endif
      DONE: if (accept_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      settle_q <= 1'b0;
      k_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      xs_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      m1a_q    <= '0;
      m1b_q    <= '0;
      m2a_q    <= '0;
      m2b_q    <= '0;
      x_out_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      k_q      <= k_d;
      y_q      <= y_d;
      r_q      <= r_d;
      xs_q     <= xs_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      m1a_q    <= m1a_d;
      m1b_q    <= m1b_d;
      m2a_q    <= m2a_d;
      m2b_q    <= m2b_d;
      x_out_q  <= x_out_d;
      ready_q  <= ready_d;
    end
  end

  assign accept_out = (state_q == IDLE);
  assign ready_out  = ready_q;
  assign x_out      = x_out_q;

endmodule
